rv32i_fetch: RTL and testbench

- Instruction fetch stage of the rv32i pipeline, directly upstream of the decode stage.
- Owns the fetch PC and issues single-outstanding word reads to instruction memory.
- Buffers returned words in a 2-entry FIFO of {pc, instruction} and presents them to decode with a one-cycle `data_ready_o` strobe per instruction.
- Redirects (JAL/JALR/branch/trap) flush the FIFO and discard any in-flight response.

---
 rtl/rv32i_fetch_if.sv | 25 ++
 rtl/rv32i_fetch.sv | 167 ++++++++++++++++
 tb/tb_rv32i_fetch.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_fetch_if.sv
// rv32i fetch to instruction memory read bus.
// Single outstanding read; request is held until ack.
interface rv32i_fetch_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_ack_i;
  logic [ILEN-1:0] mem_data_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_data_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_data_i
  );
endinterface

// File: rtl/rv32i_fetch.sv
// rv32i fetch stage: fetch PC, single-outstanding imem reads, 2-entry FIFO.
// Define RV32I_FETCH_MISALIGN_EN to halt on misaligned redirects.
module rv32i_fetch #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  rv32i_fetch_if.master   imem,
  output logic [ILEN-1:0] instruction_o,
  output logic [XLEN-1:0] pc_data_o,
  output logic            data_ready_o,
  output logic            misaligned_o
);

`ifdef RV32I_FETCH_MISALIGN_EN
  typedef enum logic [1:0] {
    S_FETCH,
    S_DROP,
    S_HALT
  } state_e;
`else
  typedef enum logic {
    S_FETCH,
    S_DROP
  } state_e;
`endif

  state_e          state_q, state_d, run_st;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] hpc_q, hpc_d, tpc_q, tpc_d;
  logic [ILEN-1:0] hins_q, hins_d, tins_q, tins_d;
  logic            mis_q, mis_d;
  logic            ack, hold, pop, push, bad;
  logic [1:0]      widx;
  logic [XLEN-1:0] tgt;

`ifdef RV32I_FETCH_MISALIGN_EN
  assign bad          = |redirect_addr_i[1:0];
  assign tgt          = redirect_addr_i;
  assign misaligned_o = mis_q;
`else
  logic unused_lsb;
  assign unused_lsb   = ^redirect_addr_i[1:0];
  assign bad          = 1'b0;
  assign tgt          = {redirect_addr_i[XLEN-1:2], 2'b00};
  assign misaligned_o = 1'b0;
`endif

  assign imem.mem_req_o  = req_q;
  assign imem.mem_addr_o = addr_q;
  assign instruction_o   = hins_q;
  assign pc_data_o       = hpc_q;
  assign pop          = (cnt_q != 2'd0) & ~stall_i & ~redirect_i;
  assign data_ready_o = pop;

  always_comb begin
    ack     = req_q & imem.mem_ack_i;
    hold    = req_q & ~imem.mem_ack_i;
    push    = ack & (state_q == S_FETCH) & ~redirect_i;
    widx    = cnt_q - {1'b0, pop};
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    hpc_d   = hpc_q;
    hins_d  = hins_q;
    tpc_d   = tpc_q;
    tins_d  = tins_q;
    mis_d   = redirect_i ? bad : mis_q;
`ifdef RV32I_FETCH_MISALIGN_EN
    run_st  = mis_d ? S_HALT : S_FETCH;
`else
    run_st  = S_FETCH;
`endif

    if (redirect_i) begin
      cnt_d = 2'd0;
      pc_d  = tgt;
    end else begin
      if (pop) begin
        hpc_d  = tpc_q;
        hins_d = tins_q;
      end
      if (push) begin
        if (widx == 2'd0) begin
          hpc_d  = addr_q;
          hins_d = imem.mem_data_i;
        end else begin
          tpc_d  = addr_q;
          tins_d = imem.mem_data_i;
        end
        pc_d = pc_q + XLEN'(4);
      end
      cnt_d = widx + {1'b0, push};
    end

    unique case (state_q)
      S_FETCH: begin
        if (redirect_i && hold)
          state_d = S_DROP;
        else if (redirect_i)
          state_d = run_st;
      end
      S_DROP: begin
        if (ack)
          state_d = run_st;
      end
`ifdef RV32I_FETCH_MISALIGN_EN
      S_HALT: begin
        if (!mis_d)
          state_d = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // A pending request keeps its address even across redirects.
    if (hold) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      req_d  = (state_d == S_FETCH) & (cnt_d <= 2'd1);
      addr_d = pc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      cnt_q   <= 2'd0;
      hpc_q   <= '0;
      hins_q  <= '0;
      tpc_q   <= '0;
      tins_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      hpc_q   <= hpc_d;
      hins_q  <= hins_d;
      tpc_q   <= tpc_d;
      tins_q  <= tins_d;
      mis_q   <= mis_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i)
      assert (!(push && widx == 2'd2));
  end
`endif

endmodule

// File: tb/tb_rv32i_fetch.sv
// Bench for rv32i_fetch: directed scenarios plus a randomized run
// checked against a queue model of the fetch stream.
module tb_rv32i_fetch;
  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = '0;
  logic [31:0] instruction_o;
  logic [31:0] pc_data_o;
  logic        data_ready_o;
  logic        misaligned_o;

  int vectors = 0;
  int miscompares = 0;
  int lat = 0;
  int lat_cnt = 0;
  bit rnd_mode = 1'b0;
  bit ack_en = 1'b1;

  always #5 clk = ~clk;

  rv32i_fetch_if mif ();

  rv32i_fetch dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_addr_i(redirect_addr_i),
    .imem           (mif),
    .instruction_o  (instruction_o),
    .pc_data_o      (pc_data_o),
    .data_ready_o   (data_ready_o),
    .misaligned_o   (misaligned_o)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Instruction memory: fixed latency or random ack.
  assign mif.mem_ack_i  = mif.mem_req_o &&
                          (rnd_mode ? ack_en : (lat_cnt >= lat));
  assign mif.mem_data_i = word(mif.mem_addr_o);

  always @(posedge clk) begin
    if (reset_i || !mif.mem_req_o || mif.mem_ack_i)
      lat_cnt <= 0;
    else
      lat_cnt <= lat_cnt + 1;
    ack_en <= ($urandom_range(0, 2) != 0);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_addr_i = '0;
    nxt();
    nxt();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    lat = 0;
    rnd_mode = 1'b0;
    reset_i = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    repeat (3) nxt();
    @(negedge clk);
    vectors++;
    if (mif.mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_req: got %b want 0", mif.mem_req_o);
    end
    vectors++;
    if (data_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 0", data_ready_o);
    end
    vectors++;
    if (misaligned_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mis: got %b want 0", misaligned_o);
    end
    vectors++;
    if (instruction_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_instr: got %h want 0", instruction_o);
    end
    vectors++;
    if (pc_data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_pc: got %h want 0", pc_data_o);
    end
  endtask

  task automatic test_zero_wait();
    bit seen;
    bit got;
    logic [31:0] e;
    lat = 0;
    rnd_mode = 1'b0;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (mif.mem_req_o) seen = 1'b1;
      else nxt();
    end
    vectors++;
    if (!seen || mif.mem_addr_o !== 32'h0) begin
      miscompares++;
      $display("FAIL zw_first_addr: got req %b addr %h want 1 0",
               seen, mif.mem_addr_o);
    end
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      nxt();
      @(negedge clk);
      got = data_ready_o;
    end
    for (int k = 0; k < 3; k++) begin
      e = 32'(k * 4);
      if (k != 0) begin
        nxt();
        @(negedge clk);
      end
      vectors++;
      if (data_ready_o !== 1'b1 || pc_data_o !== e) begin
        miscompares++;
        $display("FAIL zw_stream: got rdy %b pc %h want 1 %h",
                 data_ready_o, pc_data_o, e);
      end
      vectors++;
      if (instruction_o !== word(e)) begin
        miscompares++;
        $display("FAIL zw_instr: got %h want %h", instruction_o, word(e));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] e;
    lat = 0;
    rnd_mode = 1'b0;
    do_reset();
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (data_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_ready: got %b want 0", data_ready_o);
      end
      if (i == 4) begin
        vectors++;
        if (mif.mem_req_o !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_req_drop: got %b want 0", mif.mem_req_o);
        end
      end
      nxt();
    end
    stall_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      e = 32'(k * 4);
      if (k != 0) nxt();
      @(negedge clk);
      vectors++;
      if (data_ready_o !== 1'b1 || pc_data_o !== e ||
          instruction_o !== word(e)) begin
        miscompares++;
        $display("FAIL stall_release: got rdy %b pc %h ins %h want 1 %h %h",
                 data_ready_o, pc_data_o, instruction_o, e, word(e));
      end
    end
  endtask

  task automatic test_redirect_drop();
    bit seen;
    bit acked;
    bit got;
    lat = 3;
    rnd_mode = 1'b0;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mif.mem_req_o && mif.mem_addr_o == 32'h8) seen = 1'b1;
      else nxt();
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL drop_req8: got none want request to 00000008");
    end
    nxt();
    redirect_i = 1'b1;
    redirect_addr_i = 32'h100;
    @(negedge clk);
    vectors++;
    if (data_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_redir_ready: got %b want 0", data_ready_o);
    end
    nxt();
    redirect_i = 1'b0;
    acked = 1'b0;
    for (int i = 0; i < 10 && !acked; i++) begin
      @(negedge clk);
      vectors++;
      if (mif.mem_req_o !== 1'b1 || mif.mem_addr_o !== 32'h8 ||
          data_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL drop_hold: got req %b addr %h rdy %b want 1 8 0",
                 mif.mem_req_o, mif.mem_addr_o, data_ready_o);
      end
      acked = mif.mem_ack_i;
      nxt();
    end
    @(negedge clk);
    vectors++;
    if (mif.mem_req_o !== 1'b1 || mif.mem_addr_o !== 32'h100) begin
      miscompares++;
      $display("FAIL drop_next_req: got req %b addr %h want 1 100",
               mif.mem_req_o, mif.mem_addr_o);
    end
    got = data_ready_o;
    for (int i = 0; i < 20 && !got; i++) begin
      nxt();
      @(negedge clk);
      got = data_ready_o;
    end
    vectors++;
    if (!got || pc_data_o !== 32'h100) begin
      miscompares++;
      $display("FAIL drop_first_pc: got rdy %b pc %h want 1 100",
               got, pc_data_o);
    end
  endtask

  task automatic test_redirect_ack();
    bit seen;
    bit got;
    lat = 3;
    rnd_mode = 1'b0;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (mif.mem_req_o && mif.mem_addr_o == 32'hc) seen = 1'b1;
      else nxt();
    end
    repeat (3) nxt();
    redirect_i = 1'b1;
    redirect_addr_i = 32'h200;
    @(negedge clk);
    vectors++;
    if (data_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rack_ready: got %b want 0", data_ready_o);
    end
    nxt();
    redirect_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (mif.mem_req_o !== 1'b1 || mif.mem_addr_o !== 32'h200) begin
      miscompares++;
      $display("FAIL rack_next_req: got req %b addr %h want 1 200",
               mif.mem_req_o, mif.mem_addr_o);
    end
    got = data_ready_o;
    for (int i = 0; i < 20 && !got; i++) begin
      nxt();
      @(negedge clk);
      got = data_ready_o;
    end
    vectors++;
    if (!got || pc_data_o !== 32'h200) begin
      miscompares++;
      $display("FAIL rack_first_pc: got rdy %b pc %h want 1 200",
               got, pc_data_o);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ea [4];
    ea[0] = 32'hffff_fff8;
    ea[1] = 32'hffff_fffc;
    ea[2] = 32'h0;
    ea[3] = 32'h4;
    lat = 0;
    rnd_mode = 1'b0;
    do_reset();
    repeat (3) nxt();
    redirect_i = 1'b1;
    redirect_addr_i = ea[0];
    nxt();
    redirect_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) nxt();
      @(negedge clk);
      if (k < 3) begin
        vectors++;
        if (mif.mem_req_o !== 1'b1 || mif.mem_addr_o !== ea[k]) begin
          miscompares++;
          $display("FAIL wrap_addr: got req %b addr %h want 1 %h",
                   mif.mem_req_o, mif.mem_addr_o, ea[k]);
        end
      end
      if (k > 0) begin
        vectors++;
        if (data_ready_o !== 1'b1 || pc_data_o !== ea[k-1] ||
            instruction_o !== word(ea[k-1])) begin
          miscompares++;
          $display("FAIL wrap_pc: got rdy %b pc %h want 1 %h",
                   data_ready_o, pc_data_o, ea[k-1]);
        end
      end
    end
  endtask

  task automatic test_misalign();
    lat = 0;
    rnd_mode = 1'b0;
    do_reset();
    repeat (3) nxt();
    redirect_i = 1'b1;
    redirect_addr_i = 32'h102;
    @(negedge clk);
    vectors++;
    if (data_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mis_redir_ready: got %b want 0", data_ready_o);
    end
    nxt();
    redirect_i = 1'b0;
`ifdef RV32I_FETCH_MISALIGN_EN
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (misaligned_o !== 1'b1 || mif.mem_req_o !== 1'b0 ||
          data_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL mis_halt: got mis %b req %b rdy %b want 1 0 0",
                 misaligned_o, mif.mem_req_o, data_ready_o);
      end
      nxt();
    end
    redirect_i = 1'b1;
    redirect_addr_i = 32'h104;
    nxt();
    redirect_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (misaligned_o !== 1'b0 || mif.mem_req_o !== 1'b1 ||
        mif.mem_addr_o !== 32'h104) begin
      miscompares++;
      $display("FAIL mis_resume: got mis %b req %b addr %h want 0 1 104",
               misaligned_o, mif.mem_req_o, mif.mem_addr_o);
    end
    nxt();
    @(negedge clk);
    vectors++;
    if (data_ready_o !== 1'b1 || pc_data_o !== 32'h104) begin
      miscompares++;
      $display("FAIL mis_resume_pc: got rdy %b pc %h want 1 104",
               data_ready_o, pc_data_o);
    end
`else
    @(negedge clk);
    vectors++;
    if (misaligned_o !== 1'b0 || mif.mem_req_o !== 1'b1 ||
        mif.mem_addr_o !== 32'h100) begin
      miscompares++;
      $display("FAIL mis_align_addr: got mis %b req %b addr %h want 0 1 100",
               misaligned_o, mif.mem_req_o, mif.mem_addr_o);
    end
    nxt();
    @(negedge clk);
    vectors++;
    if (data_ready_o !== 1'b1 || pc_data_o !== 32'h100) begin
      miscompares++;
      $display("FAIL mis_align_pc: got rdy %b pc %h want 1 100",
               data_ready_o, pc_data_o);
    end
`endif
  endtask

  // Model: accepted words form a queue; a redirect empties it, and a
  // response to a request issued before the redirect is thrown away.
  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] fpc;
    bit stale;
    bit exp_rdy;
    bit ack;
    int delivered;
    q.delete();
    fpc = 32'h0;
    stale = 1'b0;
    delivered = 0;
    rnd_mode = 1'b1;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      stall_i = ($urandom_range(0, 9) < 3);
      redirect_i = ($urandom_range(0, 24) == 0);
`ifdef RV32I_FETCH_MISALIGN_EN
      redirect_addr_i = $urandom & 32'hffff_fffc;
`else
      redirect_addr_i = $urandom;
`endif
      @(negedge clk);
      exp_rdy = (q.size() > 0) && !stall_i && !redirect_i;
      vectors++;
      if (data_ready_o !== exp_rdy) begin
        miscompares++;
        $display("FAIL rnd_ready: cycle %0d got %b want %b",
                 c, data_ready_o, exp_rdy);
      end
      if (exp_rdy) begin
        vectors++;
        if (pc_data_o !== q[0] || instruction_o !== word(q[0])) begin
          miscompares++;
          $display("FAIL rnd_head: cycle %0d got pc %h ins %h want %h %h",
                   c, pc_data_o, instruction_o, q[0], word(q[0]));
        end
        delivered++;
      end
      ack = mif.mem_req_o && mif.mem_ack_i;
      if (redirect_i) begin
        q.delete();
        fpc = redirect_addr_i & 32'hffff_fffc;
        stale = mif.mem_req_o && !ack;
      end else begin
        if (exp_rdy) void'(q.pop_front());
        if (ack && stale) begin
          stale = 1'b0;
        end else if (ack) begin
          vectors++;
          if (mif.mem_addr_o !== fpc) begin
            miscompares++;
            $display("FAIL rnd_fetch_addr: cycle %0d got %h want %h",
                     c, mif.mem_addr_o, fpc);
          end
          q.push_back(fpc);
          fpc = fpc + 32'd4;
          vectors++;
          if (q.size() > 2) begin
            miscompares++;
            $display("FAIL rnd_depth: cycle %0d got %0d want <=2",
                     c, q.size());
          end
        end
      end
      nxt();
    end
    stall_i = 1'b0;
    redirect_i = 1'b0;
    vectors++;
    if (delivered < 20) begin
      miscompares++;
      $display("FAIL rnd_progress: got %0d want >=20", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect_drop();
    test_redirect_ack();
    test_wrap();
    test_misalign();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit want completion");
    $fatal(1);
  end

endmodule
